// File: rtl/sprite_compositor.sv
// sprite_compositor: per-channel bounds check and sprite ROM addressing,
// hit/valid alignment with the external ROM latency, lowest-index priority
// among opaque pixels, and per-frame collision flags for game logic.
module sprite_compositor #(
   parameter int         NUM_SPR     = 2,
   parameter int         SPR_W       = 150,
   parameter int         SPR_H       = 157,
   parameter int         OFS_W       = 15,
   parameter int         FRM_W       = 4,
   parameter int         ROM_LAT     = 1,
   parameter logic [7:0] TRANSPARENT = 8'hE3,
   parameter logic [7:0] BG_COLOR    = 8'h3B
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             pix_valid,
   input  logic [9:0]                       current_pixel_x,
   input  logic [9:0]                       current_pixel_y,
   input  logic                             frame_start,
   input  logic [NUM_SPR-1:0]               spr_en,
   input  logic [NUM_SPR-1:0]               spr_mirror,
   input  logic [NUM_SPR*10-1:0]            posx,
   input  logic [NUM_SPR*10-1:0]            posy,
   input  logic [NUM_SPR*FRM_W-1:0]         frame_idx,
   output logic [NUM_SPR*(FRM_W+OFS_W)-1:0] rom_addr,
   input  logic [NUM_SPR*8-1:0]             rom_q,
   output logic [7:0]                       data,
   output logic                             visible_flag,
   output logic                             out_valid,
   output logic                             collide,
   output logic [NUM_SPR-1:0]               collide_mask
);

   localparam int          AW      = FRM_W + OFS_W;
   localparam logic [10:0] SPR_W_X = 11'(SPR_W);
   localparam logic [10:0] SPR_H_X = 11'(SPR_H);
   localparam logic [31:0] SPR_W_U = 32'(SPR_W);

   // 11-bit coordinates so origin + size never wraps back onto the left/top edge
   logic [10:0]           pix_x, pix_y;
   logic [NUM_SPR-1:0]    hit_d;
   logic [AW-1:0]         addr_d [NUM_SPR];
   logic [NUM_SPR*AW-1:0] rom_addr_d, rom_addr_q;

   // index 0 is the address stage; index ROM_LAT lines up with rom_q
   logic [NUM_SPR-1:0]    hit_pipe_q [ROM_LAT+1];
   logic                  vld_pipe_q [ROM_LAT+1];

   logic [NUM_SPR-1:0]    opaque;
   logic                  coll_now;
   logic [7:0]            data_d, data_q;
   logic                  vis_d, vis_q, out_valid_q;
   logic                  collide_d, collide_q;
   logic [NUM_SPR-1:0]    mask_d, mask_q;

   assign pix_x = {1'b0, current_pixel_x};
   assign pix_y = {1'b0, current_pixel_y};

   for (genvar k = 0; k < NUM_SPR; k++) begin : g_ch
      logic [10:0]      px, py, rel_x, rel_y, col;
      logic [OFS_W-1:0] ofs;

      assign px       = {1'b0, posx[10*k +: 10]};
      assign py       = {1'b0, posy[10*k +: 10]};
      assign rel_x    = pix_x - px;
      assign rel_y    = pix_y - py;
      assign col      = spr_mirror[k] ? (SPR_W_X - 11'd1 - rel_x) : rel_x;
      assign ofs      = OFS_W'(32'(rel_y) * SPR_W_U + 32'(col));
      assign hit_d[k] = spr_en[k] & pix_valid
                      & (pix_x >= px) & (pix_x < px + SPR_W_X)
                      & (pix_y >= py) & (pix_y < py + SPR_H_X);
      assign addr_d[k] = {frame_idx[FRM_W*k +: FRM_W], ofs};
   end

   // address only moves on a hit, keeping the ROM bus quiet elsewhere
   always_comb begin
      rom_addr_d = rom_addr_q;
      for (int k = 0; k < NUM_SPR; k++) begin
         if (hit_d[k]) rom_addr_d[AW*k +: AW] = addr_d[k];
      end
   end

   // address register plus hit/valid delay line matching the ROM latency
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rom_addr_q <= '0;
         for (int i = 0; i <= ROM_LAT; i++) begin
            hit_pipe_q[i] <= '0;
            vld_pipe_q[i] <= 1'b0;
         end
      end else begin
         rom_addr_q    <= rom_addr_d;
         hit_pipe_q[0] <= hit_d;
         vld_pipe_q[0] <= pix_valid;
         for (int i = 1; i <= ROM_LAT; i++) begin
            hit_pipe_q[i] <= hit_pipe_q[i-1];
            vld_pipe_q[i] <= vld_pipe_q[i-1];
         end
      end
   end

   // opacity, lowest-index priority and collision update
   always_comb begin
      opaque = '0;
      for (int k = 0; k < NUM_SPR; k++) begin
         opaque[k] = hit_pipe_q[ROM_LAT][k] & (rom_q[8*k +: 8] != TRANSPARENT);
      end
      data_d = BG_COLOR;
      vis_d  = 1'b0;
      for (int k = NUM_SPR - 1; k >= 0; k--) begin
         if (opaque[k]) begin
            data_d = rom_q[8*k +: 8];
            vis_d  = 1'b1;
         end
      end
      // two or more bits set <=> clearing the lowest set bit leaves something
      coll_now  = vld_pipe_q[ROM_LAT] & (|(opaque & (opaque - NUM_SPR'(1))));
      collide_d = frame_start ? coll_now : (collide_q | coll_now);
      mask_d    = (frame_start ? '0 : mask_q) | (coll_now ? opaque : '0);
   end

   // output and sticky collision registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q      <= BG_COLOR;
         vis_q       <= 1'b0;
         out_valid_q <= 1'b0;
         collide_q   <= 1'b0;
         mask_q      <= '0;
      end else begin
         data_q      <= data_d;
         vis_q       <= vis_d;
         out_valid_q <= vld_pipe_q[ROM_LAT];
         collide_q   <= collide_d;
         mask_q      <= mask_d;
      end
   end

   assign rom_addr     = rom_addr_q;
   assign data         = data_q;
   assign visible_flag = vis_q;
   assign out_valid    = out_valid_q;
   assign collide      = collide_q;
   assign collide_mask = mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomised pixels against a pixel-level
// reference model; a behavioural ROM with a hashed image answers rom_addr.
module tb_sprite_compositor;

   localparam int         NUM_SPR = 2;
   localparam int         SPR_W   = 150;
   localparam int         SPR_H   = 157;
   localparam int         OFS_W   = 15;
   localparam int         FRM_W   = 4;
   localparam int         ROM_LAT = 1;
   localparam int         AW      = FRM_W + OFS_W;
   localparam int         LAT     = 2 + ROM_LAT;
   localparam logic [7:0] TRANSP  = 8'hE3;
   localparam logic [7:0] BG      = 8'h3B;

   logic                     clk = 1'b0;
   logic                     rst_n, pix_valid, frame_start;
   logic [9:0]               current_pixel_x, current_pixel_y;
   logic [NUM_SPR-1:0]       spr_en, spr_mirror;
   logic [NUM_SPR*10-1:0]    posx, posy;
   logic [NUM_SPR*FRM_W-1:0] frame_idx;
   logic [NUM_SPR*AW-1:0]    rom_addr;
   logic [NUM_SPR*8-1:0]     rom_q;
   logic [7:0]               data;
   logic                     visible_flag, out_valid, collide;
   logic [NUM_SPR-1:0]       collide_mask;

   always #5 clk = ~clk;

   sprite_compositor #(
      .NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .OFS_W(OFS_W),
      .FRM_W(FRM_W), .ROM_LAT(ROM_LAT), .TRANSPARENT(TRANSP), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid),
      .current_pixel_x(current_pixel_x), .current_pixel_y(current_pixel_y),
      .frame_start(frame_start), .spr_en(spr_en), .spr_mirror(spr_mirror),
      .posx(posx), .posy(posy), .frame_idx(frame_idx), .rom_addr(rom_addr),
      .rom_q(rom_q), .data(data), .visible_flag(visible_flag),
      .out_valid(out_valid), .collide(collide), .collide_mask(collide_mask)
   );

   // sprite image: hashed bytes, roughly a quarter transparent; force_* pins a channel
   logic [NUM_SPR-1:0] force_en;
   logic [7:0]         force_val [NUM_SPR];

   function automatic logic [7:0] rom_byte(int k, logic [AW-1:0] a);
      logic [31:0] h;
      if (force_en[k]) return force_val[k];
      h = (32'(a) * 32'h9E3779B1) ^ (32'(k + 1) * 32'h85EBCA6B);
      h = h ^ (h >> 13);
      if (h[1:0] == 2'b00) return TRANSP;
      if (h[15:8] == TRANSP) return 8'h5A;
      return h[15:8];
   endfunction

   logic [NUM_SPR*8-1:0] rom_pipe [ROM_LAT];
   always @(posedge clk) begin
      for (int i = ROM_LAT - 1; i >= 1; i--) rom_pipe[i] <= rom_pipe[i-1];
      for (int k = 0; k < NUM_SPR; k++)
         rom_pipe[0][8*k +: 8] <= rom_byte(k, rom_addr[AW*k +: AW]);
   end
   assign rom_q = rom_pipe[ROM_LAT-1];

   // reference model state
   typedef struct {
      bit                 vld;
      logic [7:0]         data;
      bit                 vis;
      logic [NUM_SPR-1:0] opq;
   } res_t;

   res_t               expq[$];
   logic [AW-1:0]      last_addr [NUM_SPR];
   bit                 exp_coll;
   logic [NUM_SPR-1:0] exp_mask;
   int                 sx [NUM_SPR];
   int                 sy [NUM_SPR];
   int                 sfi [NUM_SPR];
   int                 n_tests = 0;
   int                 n_fail  = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      res_t e;
      e.vld = 0; e.data = BG; e.vis = 0; e.opq = '0;
      expq.delete();
      repeat (LAT - 1) expq.push_back(e);
      for (int k = 0; k < NUM_SPR; k++) last_addr[k] = '0;
      exp_coll = 0;
      exp_mask = '0;
   endtask

   // one pixel clock: drive, predict, clock, compare
   task automatic step();
      res_t                  r, o;
      int                    cx, cy, rx, ry, col, off;
      logic [7:0]            b;
      logic [NUM_SPR*AW-1:0] ea;
      bit                    cn;
      for (int k = 0; k < NUM_SPR; k++) begin
         posx[10*k +: 10]           = 10'(sx[k]);
         posy[10*k +: 10]           = 10'(sy[k]);
         frame_idx[FRM_W*k +: FRM_W] = FRM_W'(sfi[k]);
      end
      cx = int'(current_pixel_x);
      cy = int'(current_pixel_y);
      r.vld = pix_valid; r.data = BG; r.vis = 0; r.opq = '0;
      for (int k = 0; k < NUM_SPR; k++) begin
         if (spr_en[k] && pix_valid && cx >= sx[k] && cx < sx[k] + SPR_W &&
             cy >= sy[k] && cy < sy[k] + SPR_H) begin
            rx  = cx - sx[k];
            ry  = cy - sy[k];
            col = spr_mirror[k] ? SPR_W - 1 - rx : rx;
            off = (ry * SPR_W + col) % (1 << OFS_W);
            last_addr[k] = AW'(sfi[k] * (1 << OFS_W) + off);
            b = rom_byte(k, last_addr[k]);
            if (b != TRANSP) begin
               r.opq[k] = 1'b1;
               if (!r.vis) begin
                  r.vis  = 1;
                  r.data = b;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         model_reset();
         chk("rst_data", data, BG);
         chk("rst_vis", visible_flag, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_collide", collide, 0);
         chk("rst_mask", collide_mask, 0);
         chk("rst_rom_addr", rom_addr, 0);
      end else begin
         expq.push_back(r);
         o  = expq.pop_front();
         cn = o.vld && ($countones(o.opq) >= 2);
         if (frame_start) begin
            exp_coll = cn;
            exp_mask = cn ? o.opq : '0;
         end else begin
            exp_coll = exp_coll | cn;
            if (cn) exp_mask = exp_mask | o.opq;
         end
         for (int k = 0; k < NUM_SPR; k++) ea[AW*k +: AW] = last_addr[k];
         chk("data", data, o.data);
         chk("visible_flag", visible_flag, o.vis);
         chk("out_valid", out_valid, o.vld);
         chk("collide", collide, exp_coll);
         chk("collide_mask", collide_mask, exp_mask);
         chk("rom_addr", rom_addr, ea);
      end
   endtask

   // one pixel followed by idle cycles until it reaches the output
   task automatic pix_and_wait(int x, int y, bit fs_last);
      pix_valid = 1;
      current_pixel_x = 10'(x);
      current_pixel_y = 10'(y);
      step();
      pix_valid = 0;
      for (int i = 1; i < LAT; i++) begin
         frame_start = (i == LAT - 1) ? fs_last : 1'b0;
         step();
      end
      frame_start = 0;
   endtask

   initial begin
      int kk, cx;
      rst_n = 0; pix_valid = 1; frame_start = 0;
      current_pixel_x = 10'd120; current_pixel_y = 10'd60;
      spr_en = '1; spr_mirror = '0;
      force_en = '0;
      for (int k = 0; k < NUM_SPR; k++) begin
         sx[k] = 100; sy[k] = 50; sfi[k] = 0; force_val[k] = 8'h00;
      end
      model_reset();

      // reset with valid pixels pending, then released with idle input
      repeat (2) step();
      rst_n = 1; pix_valid = 0;
      repeat (3) begin
         step();
         chk("post_rst_data", data, BG);
         chk("post_rst_out_valid", out_valid, 0);
         chk("post_rst_collide", collide, 0);
      end

      // origin pixel: offset 0 is drawn
      spr_en = 2'b01; force_en = 2'b01; force_val[0] = 8'h77;
      sx[0] = 100; sy[0] = 50; sfi[0] = 2;
      pix_and_wait(100, 50, 0);
      chk("origin_addr", rom_addr[AW-1:0], {4'd2, 15'd0});
      chk("origin_data", data, 8'h77);
      chk("origin_vis", visible_flag, 1);

      // mirrored row 1, column 0 -> offset 150 + 149
      spr_mirror = 2'b01;
      pix_and_wait(100, 51, 0);
      chk("mirror_addr", rom_addr[AW-1:0], {4'd2, 15'd299});
      chk("mirror_vis", visible_flag, 1);
      pix_and_wait(250, 50, 0);
      chk("right_edge_vis", visible_flag, 0);
      chk("right_edge_data", data, BG);
      chk("right_edge_addr_hold", rom_addr[AW-1:0], {4'd2, 15'd299});
      pix_and_wait(99, 50, 0);
      chk("left_edge_vis", visible_flag, 0);
      spr_mirror = '0;

      // priority and collision
      spr_en = 2'b11; force_en = 2'b11;
      force_val[0] = 8'h12; force_val[1] = 8'h34;
      sx[0] = 200; sy[0] = 100; sx[1] = 200; sy[1] = 100;
      pix_and_wait(210, 110, 0);
      chk("prio_data", data, 8'h12);
      chk("prio_collide", collide, 1);
      chk("prio_mask", collide_mask, 2'b11);
      force_val[0] = TRANSP;
      pix_and_wait(210, 110, 0);
      chk("prio_transp_data", data, 8'h34);
      chk("prio_transp_vis", visible_flag, 1);

      // frame clear, then frame_start coinciding with an overlap
      frame_start = 1;
      step();
      frame_start = 0;
      chk("fclear_collide", collide, 0);
      chk("fclear_mask", collide_mask, 0);
      force_val[0] = 8'h12;
      pix_and_wait(210, 110, 1);
      chk("fcoincide_collide", collide, 1);
      chk("fcoincide_mask", collide_mask, 2'b11);

      // right-edge origin does not wrap; disabled channel is invisible
      spr_en = 2'b01; sx[0] = 1000; sy[0] = 0;
      pix_and_wait(5, 5, 0);
      chk("nowrap_vis", visible_flag, 0);
      pix_and_wait(1010, 5, 0);
      chk("edge_hit_data", data, 8'h12);
      spr_en = 2'b00;
      pix_and_wait(1010, 5, 0);
      chk("disabled_vis", visible_flag, 0);

      // randomised traffic
      force_en = '0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 100 == 0) begin
            for (int k = 0; k < NUM_SPR; k++) begin
               sx[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(900, 1023))
                                                   : int'($urandom_range(0, 250));
               sy[k] = int'($urandom_range(0, 200));
            end
            spr_en     = NUM_SPR'($urandom);
            spr_mirror = NUM_SPR'($urandom);
         end
         for (int k = 0; k < NUM_SPR; k++) sfi[k] = int'($urandom_range(0, 15));
         kk = int'($urandom_range(0, NUM_SPR - 1));
         if ($urandom_range(0, 7) == 0) begin
            current_pixel_x = 10'($urandom);
            current_pixel_y = 10'($urandom);
         end else begin
            cx = sx[kk] + int'($urandom_range(0, SPR_W + 9)) - 5;
            current_pixel_x = 10'((cx < 0) ? 0 : (cx > 1023) ? 1023 : cx);
            current_pixel_y = 10'(sy[kk] + int'($urandom_range(0, SPR_H + 9)) - 5);
         end
         pix_valid   = ($urandom_range(0, 7) != 0);
         frame_start = ($urandom_range(0, 49) == 0);
         rst_n       = ($urandom_range(0, 499) != 0);
         step();
      end
      rst_n = 1; frame_start = 0; pix_valid = 0;
      repeat (LAT) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
